// File: rtl/fir_mac_mc_if.sv
// Sample-in / result-out / coefficient-memory bundle of the multi-channel FIR.
interface fir_mac_mc_if #(
    parameter int unsigned DATA_W  = 18,
    parameter int unsigned COEF_W  = 18,
    parameter int unsigned NCHAN   = 2,
    parameter int unsigned CADDR_W = 8
);
    localparam int unsigned CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic signed [DATA_W-1:0]  datain;
    logic        [CH_W-1:0]    datain_chan;
    logic                      endata;
    logic                      busy;
    logic signed [DATA_W-1:0]  dataout;
    logic        [CH_W-1:0]    dataout_chan;
    logic                      dataout_valid;
    logic                      sat;
    logic                      overrun;
    logic        [CADDR_W-1:0] coefaddress;
    logic signed [COEF_W-1:0]  coefdata;

    modport slave (
        input  datain, datain_chan, endata, coefdata,
        output busy, dataout, dataout_chan, dataout_valid, sat, overrun, coefaddress
    );

    modport master (
        output datain, datain_chan, endata, coefdata,
        input  busy, dataout, dataout_chan, dataout_valid, sat, overrun, coefaddress
    );
endinterface

// File: rtl/fir_mac_mc.sv
// Time-multiplexed multi-channel FIR: one shared MAC computes one tap per clock,
// coefficients come from an external synchronous memory with COEF_LAT read latency.
module fir_mac_mc #(
    parameter int unsigned DATA_W        = 18,
    parameter int unsigned COEF_W        = 18,
    parameter int unsigned NTAPS         = 65,
    parameter int unsigned NCHAN         = 2,
    parameter int unsigned SHIFT         = 12,
    parameter int unsigned COEF_LAT      = 1,
    parameter int unsigned PER_CHAN_COEF = 1,
    parameter int unsigned CADDR_W       = 8
) (
    input  logic          clock,
    input  logic          reset,
    fir_mac_mc_if.slave   bus
);
    localparam int unsigned CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int unsigned KW   = $clog2(NTAPS);
    localparam int unsigned PW   = DATA_W + COEF_W;
    localparam int unsigned AW   = PW + $clog2(NTAPS);
    localparam int unsigned RW   = AW + 1;
    localparam int unsigned XD   = COEF_LAT + 1;
    localparam int unsigned DW   = $clog2(COEF_LAT + 2);
    localparam int unsigned RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? (RW'(1) << RSH) : RW'(0);
    localparam logic signed [RW-1:0] MAXV = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic        [KW-1:0]      k_q, k_d;
    logic        [DW-1:0]      dcnt_q, dcnt_d;
    logic        [CH_W-1:0]    ch_q, ch_d;
    logic        [CADDR_W-1:0] caddr_q, caddr_d;
    logic signed [DATA_W-1:0]  xpipe_q [XD];
    logic signed [DATA_W-1:0]  xpipe_d [XD];
    logic signed [PW-1:0]      prod_q, prod_d;
    logic signed [AW-1:0]      acc_q, acc_d;
    logic signed [DATA_W-1:0]  hist_q [NCHAN][NTAPS];
    logic signed [DATA_W-1:0]  hist_d [NCHAN][NTAPS];
    logic signed [DATA_W-1:0]  dout_q, dout_d;
    logic        [CH_W-1:0]    dchan_q, dchan_d;
    logic                      dvalid_q, dvalid_d;
    logic                      sat_q, sat_d;
    logic                      ovr_q, ovr_d;
    logic                      busy_q, busy_d;

    logic                      chan_ok_c;
    logic                      accept_c;
    logic        [KW-1:0]      nxt_k_c;
    logic signed [DATA_W-1:0]  tap_x_c;
    logic signed [RW-1:0]      rnd_c, shr_c;

    // Coefficient address of tap k in the bank owned by channel ch.
    function automatic logic [CADDR_W-1:0] addr_f(input logic [CH_W-1:0] ch, input logic [KW-1:0] k);
        int unsigned base;
        base = (PER_CHAN_COEF != 0) ? 32'(ch) * NTAPS : 32'd0;
        return CADDR_W'(base + 32'(k));
    endfunction

    assign chan_ok_c = (32'(bus.datain_chan) < NCHAN);
    assign nxt_k_c   = k_q + KW'(1);
    assign rnd_c     = RW'(acc_q) + RND;
    assign shr_c     = rnd_c >>> SHIFT;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        dcnt_d   = dcnt_q;
        ch_d     = ch_q;
        caddr_d  = '0;
        hist_d   = hist_q;
        dout_d   = dout_q;
        dchan_d  = dchan_q;
        dvalid_d = 1'b0;
        sat_d    = 1'b0;
        ovr_d    = ovr_q;
        accept_c = 1'b0;
        tap_x_c  = '0;
        prod_d   = PW'(xpipe_q[XD-1]) * PW'(bus.coefdata);
        acc_d    = acc_q + AW'(prod_q);

        if (bus.endata) begin
            if (busy_q || !chan_ok_c) ovr_d = 1'b1;
            else                      accept_c = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_RUN;
                    ch_d    = bus.datain_chan;
                    k_d     = '0;
                    caddr_d = addr_f(bus.datain_chan, KW'(0));
                    tap_x_c = bus.datain;
                    acc_d   = '0;
                    for (int c = 0; c < int'(NCHAN); c++) begin
                        if (CH_W'(c) == bus.datain_chan) begin
                            for (int j = int'(NTAPS) - 1; j > 0; j--) hist_d[c][j] = hist_q[c][j-1];
                            hist_d[c][0] = bus.datain;
                        end
                    end
                end
            end
            S_RUN: begin
                if (k_q == KW'(NTAPS - 1)) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    k_d     = nxt_k_c;
                    caddr_d = addr_f(ch_q, nxt_k_c);
                    tap_x_c = hist_q[ch_q][nxt_k_c];
                end
            end
            // Covers the memory read latency plus the product register stage.
            S_DRAIN: begin
                if (dcnt_q == DW'(COEF_LAT)) state_d = S_OUT;
                else                         dcnt_d  = dcnt_q + DW'(1);
            end
            S_OUT: begin
                state_d  = S_IDLE;
                dvalid_d = 1'b1;
                dchan_d  = ch_q;
                if (shr_c > MAXV) begin
                    dout_d = MAXV[DATA_W-1:0];
                    sat_d  = 1'b1;
                end else if (shr_c < MINV) begin
                    dout_d = MINV[DATA_W-1:0];
                    sat_d  = 1'b1;
                end else begin
                    dout_d = shr_c[DATA_W-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        xpipe_d[0] = tap_x_c;
        for (int i = 1; i < int'(XD); i++) xpipe_d[i] = xpipe_q[i-1];

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            dcnt_q   <= '0;
            ch_q     <= '0;
            caddr_q  <= '0;
            xpipe_q  <= '{default: '0};
            prod_q   <= '0;
            acc_q    <= '0;
            hist_q   <= '{default: '{default: '0}};
            dout_q   <= '0;
            dchan_q  <= '0;
            dvalid_q <= 1'b0;
            sat_q    <= 1'b0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            dcnt_q   <= dcnt_d;
            ch_q     <= ch_d;
            caddr_q  <= caddr_d;
            xpipe_q  <= xpipe_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            hist_q   <= hist_d;
            dout_q   <= dout_d;
            dchan_q  <= dchan_d;
            dvalid_q <= dvalid_d;
            sat_q    <= sat_d;
            ovr_q    <= ovr_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.dataout       = dout_q;
    assign bus.dataout_chan  = dchan_q;
    assign bus.dataout_valid = dvalid_q;
    assign bus.sat           = sat_q;
    assign bus.overrun       = ovr_q;
    assign bus.coefaddress   = caddr_q;
endmodule
